// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: start/pause controller for an LED pattern generator.
// Paces the generator with a step strobe at a selectable rate, latches its
// pattern one cycle after each step, counts sweeps and PWM-dims the LEDs.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   btn_start   start/stop pulse (debounced, one cycle)
//   btn_pause   pause/resume pulse (debounced, one cycle)
//   speed_sel   step period = BASE_DIV >> speed_sel
//   dim_sel     brightness: 0/1/2/3 -> 16/16, 8/16, 4/16, 1/16 duty
//   pattern_in  pattern from the upstream generator
//   step        one-cycle generator advance strobe
//   gen_clr     generator clear, high while idle
//   led         dimmed display register
//   state       IDLE=0, RUN=1, PAUSE=2
//   loop_cnt    completed sweeps, wraps at 256
module led_pattern_ctrl #(
    parameter int unsigned BASE_DIV = 25_000_000,
    parameter int unsigned STEPS    = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_pause,
    input  logic [1:0]  speed_sel,
    input  logic [1:0]  dim_sel,
    input  logic [15:0] pattern_in,
    output logic        step,
    output logic        gen_clr,
    output logic [15:0] led,
    output logic [1:0]  state,
    output logic [7:0]  loop_cnt
);

    localparam int unsigned PW = $clog2(BASE_DIV);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          step_q, step_d;
    logic          cap_q, cap_d;
    logic [15:0]   disp_q, disp_d;
    logic [SW-1:0] scnt_q, scnt_d;
    logic [7:0]    loop_q, loop_d;
    logic [3:0]    pwm_q, pwm_d;
    logic [15:0]   led_q, led_d;
    logic          gen_clr_q, gen_clr_d;

    logic [CW-1:0] per_m1_c;
    logic [CW-1:0] raw_c;
    logic [4:0]    duty_c;
    logic          pwm_on_c;
    logic          capture_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start has priority over pause
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (btn_start) state_d = RUN;
            end
            RUN: begin
                if (btn_start)      state_d = IDLE;
                else if (btn_pause) state_d = PAUSE;
            end
            PAUSE: begin
                if (btn_start)      state_d = IDLE;
                else if (btn_pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values
    always_comb begin
        per_m1_c  = (CW'(BASE_DIV) >> speed_sel) - CW'(1);
        raw_c     = CW'(presc_q);
        presc_d   = presc_q;
        step_d    = 1'b0;
        capture_c = cap_q && (state_q == RUN) && (state_d == RUN);
        disp_d    = disp_q;
        cap_d     = cap_q;
        scnt_d    = scnt_q;
        loop_d    = loop_q;
        pwm_d     = pwm_q + 4'd1;
        duty_c    = 5'd16;
        gen_clr_d = (state_d == IDLE);

        // Prescaler value for the coming cycle: wraps after a step, otherwise
        // advances while running and holds when entering from IDLE/PAUSE.
        if (state_q == RUN) begin
            raw_c = step_q ? '0 : (CW'(presc_q) + CW'(1));
        end

        if (state_d == RUN) begin
            // Landing on or past the terminal count (e.g. after a speed
            // increase) clamps to P-1 so the step shows for exactly one cycle.
            if (raw_c >= per_m1_c) begin
                presc_d = PW'(per_m1_c);
                step_d  = 1'b1;
            end else begin
                presc_d = PW'(raw_c);
            end
        end else if (state_d == PAUSE) begin
            // A step already issued on the pause edge must not repeat on resume
            presc_d = (state_q == RUN && step_q) ? '0 : presc_q;
        end else begin
            presc_d = '0;
        end

        if (state_d == IDLE) begin
            disp_d = '0;
            cap_d  = 1'b0;
            scnt_d = '0;
            loop_d = '0;
        end else begin
            if (capture_c) disp_d = pattern_in;
            // Capture is one cycle after step; a pending one survives PAUSE
            cap_d = step_q | (cap_q & ~capture_c);
            if (step_q) begin
                if (scnt_q == SW'(STEPS - 1)) begin
                    scnt_d = '0;
                    loop_d = loop_q + 8'd1;
                end else begin
                    scnt_d = scnt_q + SW'(1);
                end
            end
        end

        case (dim_sel)
            2'd0:    duty_c = 5'd16;
            2'd1:    duty_c = 5'd8;
            2'd2:    duty_c = 5'd4;
            default: duty_c = 5'd1;
        endcase
        pwm_on_c = ({1'b0, pwm_q} < duty_c);
        led_d    = (state_d == IDLE) ? '0 : (disp_q & {16{pwm_on_c}});
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            step_q    <= 1'b0;
            cap_q     <= 1'b0;
            disp_q    <= '0;
            scnt_q    <= '0;
            loop_q    <= '0;
            pwm_q     <= '0;
            led_q     <= '0;
            gen_clr_q <= 1'b1;
        end else begin
            presc_q   <= presc_d;
            step_q    <= step_d;
            cap_q     <= cap_d;
            disp_q    <= disp_d;
            scnt_q    <= scnt_d;
            loop_q    <= loop_d;
            pwm_q     <= pwm_d;
            led_q     <= led_d;
            gen_clr_q <= gen_clr_d;
        end
    end

    assign step     = step_q;
    assign gen_clr  = gen_clr_q;
    assign led      = led_q;
    assign state    = state_q;
    assign loop_cnt = loop_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed, table-driven checks of led_pattern_ctrl
// with BASE_DIV=8 and STEPS=9.
module tb_led_pattern_ctrl;

    logic        clk;
    logic        rst;
    logic        btn_start;
    logic        btn_pause;
    logic [1:0]  speed_sel;
    logic [1:0]  dim_sel;
    logic [15:0] pattern_in;
    logic        step;
    logic        gen_clr;
    logic [15:0] led;
    logic [1:0]  state;
    logic [7:0]  loop_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    led_pattern_ctrl #(
        .BASE_DIV (8),
        .STEPS    (9)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_pause  (btn_pause),
        .speed_sel  (speed_sel),
        .dim_sel    (dim_sel),
        .pattern_in (pattern_in),
        .step       (step),
        .gen_clr    (gen_clr),
        .led        (led),
        .state      (state),
        .loop_cnt   (loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] speed;
        logic [1:0] dim;
        int         first;
        int         period;
        int         on_cnt;
    } vec_t;

    vec_t vecs[4];

    // Advance one edge; outputs are read 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        btn_start = 1'b1;
        tick();
        btn_start = 1'b0;
    endtask

    task automatic pulse_pause();
        btn_pause = 1'b1;
        tick();
        btn_pause = 1'b0;
    endtask

    // Cycles until step is seen high (0 if already high)
    task automatic wait_step(input int budget, output int n);
        n = 0;
        while (step !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (step !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_step: no step within %0d cycles", budget);
        end
    endtask

    initial begin
        int n;
        int cnt_a;
        int cnt_b;

        vecs[0] = '{speed: 2'd0, dim: 2'd0, first: 7, period: 8, on_cnt: 16};
        vecs[1] = '{speed: 2'd1, dim: 2'd1, first: 3, period: 4, on_cnt: 8};
        vecs[2] = '{speed: 2'd2, dim: 2'd2, first: 1, period: 2, on_cnt: 4};
        vecs[3] = '{speed: 2'd3, dim: 2'd3, first: 0, period: 1, on_cnt: 1};

        rst        = 1'b1;
        btn_start  = 1'b0;
        btn_pause  = 1'b0;
        speed_sel  = 2'd0;
        dim_sel    = 2'd0;
        pattern_in = 16'h0000;
        tick();
        tick();

        // Reset values
        chk("rst_state",   32'(state),    32'd0);
        chk("rst_step",    32'(step),     32'd0);
        chk("rst_gen_clr", 32'(gen_clr),  32'd1);
        chk("rst_led",     32'(led),      32'h0);
        chk("rst_loop",    32'(loop_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Table: step latency/period per speed and PWM duty per dim
        for (int i = 0; i < 4; i++) begin
            speed_sel  = vecs[i].speed;
            dim_sel    = vecs[i].dim;
            pattern_in = 16'hFFFF;
            pulse_start();
            wait_step(40, n);
            chk($sformatf("v%0d_first", i), 32'(n), 32'(vecs[i].first));
            tick();
            wait_step(40, n);
            chk($sformatf("v%0d_period", i), 32'(n + 1), 32'(vecs[i].period));
            tick();
            tick();
            tick();
            cnt_a = 0;
            for (int k = 0; k < 16; k++) begin
                if (led != 16'h0000) cnt_a++;
                tick();
            end
            chk($sformatf("v%0d_on_cnt", i), 32'(cnt_a), 32'(vecs[i].on_cnt));
            pulse_start();
            chk($sformatf("v%0d_stop_state", i), 32'(state), 32'd0);
            chk($sformatf("v%0d_stop_led", i),   32'(led),   32'h0);
        end

        // Step timing and pattern capture
        speed_sel  = 2'd0;
        dim_sel    = 2'd0;
        pattern_in = 16'h0000;
        pulse_start();
        chk("run_gen_clr", 32'(gen_clr), 32'd0);
        wait_step(40, n);
        chk("first_step", 32'(n), 32'd7);
        tick();
        pattern_in = 16'h0180;
        tick();
        chk("cap_led_early", 32'(led), 32'h0);
        tick();
        chk("cap_led", 32'(led), 32'h0180);
        wait_step(40, n);
        chk("second_step", 32'(n), 32'd5);

        // Pause with prescaler at 3
        tick();
        tick();
        tick();
        tick();
        pulse_pause();
        chk("pause_state", 32'(state), 32'd2);
        chk("pause_gen_clr", 32'(gen_clr), 32'd0);
        pattern_in = 16'hFFFF;
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (step !== 1'b0) cnt_a++;
            if (led !== 16'h0180) cnt_b++;
        end
        chk("pause_no_step", 32'(cnt_a), 32'd0);
        chk("pause_led_held", 32'(cnt_b), 32'd0);
        pulse_pause();
        chk("resume_state", 32'(state), 32'd1);
        wait_step(40, n);
        chk("resume_step", 32'(n), 32'd4);

        // Speed change with prescaler at 5 -> P=2
        for (int k = 0; k < 6; k++) tick();
        speed_sel = 2'd2;
        tick();
        chk("spd_step_next", 32'(step), 32'd1);
        tick();
        chk("spd_step_gap", 32'(step), 32'd0);
        tick();
        chk("spd_step_again", 32'(step), 32'd1);
        speed_sel = 2'd0;

        // Dimming and sweep counting
        pulse_start();
        chk("stop_loop", 32'(loop_cnt), 32'd0);
        dim_sel    = 2'd2;
        pattern_in = 16'hFFFF;
        pulse_start();
        for (int k = 0; k < 18; k++) begin
            wait_step(40, n);
            tick();
            if (k == 8) chk("loop_after_9", 32'(loop_cnt), 32'd1);
        end
        chk("loop_after_18", 32'(loop_cnt), 32'd2);
        cnt_a = 0;
        for (int k = 0; k < 16; k++) begin
            if (led != 16'h0000) cnt_a++;
            tick();
        end
        chk("dim2_on_cnt", 32'(cnt_a), 32'd4);

        // Simultaneous start and pause in RUN
        btn_start = 1'b1;
        btn_pause = 1'b1;
        tick();
        btn_start = 1'b0;
        btn_pause = 1'b0;
        chk("both_state",   32'(state),    32'd0);
        chk("both_led",     32'(led),      32'h0);
        chk("both_gen_clr", 32'(gen_clr),  32'd1);
        chk("both_loop",    32'(loop_cnt), 32'd0);
        chk("both_step",    32'(step),     32'd0);

        // Pause ignored in IDLE
        pulse_pause();
        chk("idle_pause", 32'(state), 32'd0);
        tick();
        chk("idle_pause_hold", 32'(state), 32'd0);

        // Stop in the step cycle discards the pending capture
        dim_sel    = 2'd0;
        pattern_in = 16'hFFFF;
        pulse_start();
        wait_step(40, n);
        pulse_start();
        chk("discard_state", 32'(state), 32'd0);
        pulse_start();
        tick();
        tick();
        chk("discard_led", 32'(led), 32'h0);

        // Asynchronous reset mid-RUN
        speed_sel = 2'd3;
        for (int k = 0; k < 12; k++) tick();
        chk("pre_rst_loop", 32'(loop_cnt), 32'd1);
        chk("pre_rst_led",  32'(led),      32'hFFFF);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_state",   32'(state),    32'd0);
        chk("arst_step",    32'(step),     32'd0);
        chk("arst_gen_clr", 32'(gen_clr),  32'd1);
        chk("arst_led",     32'(led),      32'h0);
        chk("arst_loop",    32'(loop_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_idle", 32'(state), 32'd0);
        pulse_start();
        chk("post_rst_run", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
